multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
Multi-cycle sequencer for the lab RV32I datapath (instruction decoder, ALU, register file). It owns the PC and instruction register, fetches each instruction over a req/ack handshake, and steps it through decode, execute and write-back. It gates the register-file write enable to the write-back cycle. It halts on an illegal opcode or a fetch timeout, and supports single-step operation for the debug console.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset
TIMEOUT, 255, max FETCH cycles waiting for imem_ack before fault; 0 disables the timeout
TW, 8, width of the timeout counter; must hold TIMEOUT

Ports:
clk  in  1  system clock, all state updates on rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  pulse; leaves IDLE
step_mode  in  1  1 = return to IDLE after each retired instruction
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= pc)
imem_rdata  in  32  fetched instruction
imem_ack  in  1  fetch data valid
ir  out  32  instruction register, drives decoder inst
pc  out  32  current PC, ALU src0 when alu_src0_sel=1
dec_alu_op  in  5  decoder alu_op; 5'b11111 = illegal
dec_rf_we  in  1  decoder rf_we
rf_we  out  1  gated register-file write enable
busy  out  1  1 in FETCH/DECODE/EXEC/WB
halted  out  1  1 in HALT
cause  out  2  00 none, 01 illegal instruction, 10 fetch timeout
instret  out  32  retired-instruction counter

Behaviour:
- Reset (async, rstn=0) forces the following values immediately:
  - state=IDLE, pc=RESET_PC, ir=32'h0000_0013 (addi x0,x0,0)
  - imem_req=0, rf_we=0, busy=0, halted=0, cause=00, instret=0, timeout counter=0
- Reset asserted mid-operation drops imem_req and rf_we in the same instant; the in-flight instruction is discarded and pc is not advanced.
- Registered state. The only combinational outputs:
  - imem_req = (state==FETCH)
  - imem_addr = pc
  - rf_we = (state==WB) & dec_rf_we
- IDLE:
  - start=1 -> FETCH.
  - Otherwise hold.
- FETCH:
  - imem_req=1 with imem_addr held stable until ack.
  - imem_ack=1 at a clock edge -> ir<=imem_rdata, timeout counter cleared, -> DECODE.
  - Otherwise the counter increments. When TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ack -> HALT with cause=10, and ir is unchanged.
  - Ack and the timeout boundary in the same cycle: ack wins.
- DECODE (1 cycle): ir is stable and the decoder and register-file reads settle.
  - dec_alu_op==5'b11111 -> HALT with cause=01; pc and instret are not updated.
  - Else -> EXEC.
- EXEC (1 cycle): ALU result settles -> WB.
- WB (1 cycle):
  - rf_we=dec_rf_we for exactly this cycle.
  - pc<=pc+4, modulo 2^32 (wraps 32'hFFFF_FFFC -> 0).
  - instret<=instret+1, wraps.
  - Next state: step_mode=1 -> IDLE, else FETCH.
- HALT: sticky; exits only on reset. halted=1, cause held, pc points at the faulting instruction.
- start is ignored outside IDLE.
- imem_ack is ignored outside FETCH.
- step_mode is sampled only in WB.
- Latency: with imem_ack in the first FETCH cycle, an instruction takes 4 cycles (FETCH, DECODE, EXEC, WB). Each cycle of ack delay adds 1.
- busy is registered from the state: 1 in FETCH, DECODE, EXEC and WB.

Test Plan:
1. Reset, then start pulse with imem_ack tied to imem_req, program `addi x1,x0,5` (32'h0050_0093) -> imem_addr=32'h3000 on the first FETCH; rf_we=1 only in cycle 4; pc=32'h3004, instret=1 afterwards; sustained 4-cycle cadence.
2. Ack delayed 3 cycles -> imem_req held high 4 cycles with imem_addr constant; ir captured on the ack edge only; pc advances by exactly 4.
3. Fetch 32'hFFFF_FFFF (illegal) -> HALT after DECODE; halted=1, cause=01, pc unchanged, instret unchanged; rf_we never asserted; later start pulses ignored.
4. TIMEOUT=4, imem_ack held 0 -> HALT after 4 FETCH cycles with cause=10. Ack arriving on the 4th cycle instead -> no fault, proceeds to DECODE.
5. step_mode=1 -> controller returns to IDLE after each WB; each start pulse retires exactly one instruction (instret +1 per pulse).
6. rstn pulled low during FETCH (req=1) and again during WB -> imem_req and rf_we drop asynchronously; pc=RESET_PC, ir=32'h0000_0013, instret=0; restart fetches from 32'h3000.

Source files
------------

// File: rtl/multi_cycle_ctrl_if.sv
// Instruction-memory fetch port of the multi-cycle sequencer.
// Request stays high with a stable address until ack.
interface multi_cycle_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/WB with PC, IR,
// gated rf write enable, sticky halt on fault and single-step.
module multi_cycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned TW       = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               step_mode,
    multi_cycle_ctrl_if.master imem,
    output logic [31:0]        ir,
    output logic [31:0]        pc,
    input  logic [4:0]         dec_alu_op,
    input  logic               dec_rf_we,
    output logic               rf_we,
    output logic               busy,
    output logic               halted,
    output logic [1:0]         cause,
    output logic [31:0]        instret
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;

    localparam logic [4:0]    ALU_BAD = 5'b11111;
    localparam logic [31:0]   NOP     = 32'h0000_0013;
    localparam logic          TO_EN   = (TIMEOUT != 0);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    logic [2:0]    state;
    logic [2:0]    nxt;
    logic [TW-1:0] tcnt;
    logic          ack;
    logic          to_hit;
    logic          bad_op;

    assign ack    = imem.imem_ack;
    assign to_hit = TO_EN && (tcnt == TO_LAST);
    assign bad_op = (dec_alu_op == ALU_BAD);

    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = pc;
    assign rf_we          = (state == WB) & dec_rf_we;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = FETCH;
            // ack beats the timeout boundary in the same cycle
            FETCH: begin
                if (ack)         nxt = DECODE;
                else if (to_hit) nxt = HALT;
            end
            DECODE:  nxt = bad_op ? HALT : EXEC;
            EXEC:    nxt = WB;
            WB:      nxt = step_mode ? IDLE : FETCH;
            HALT:    nxt = HALT;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            ir      <= NOP;
            busy    <= 1'b0;
            halted  <= 1'b0;
            cause   <= 2'b00;
            instret <= '0;
            tcnt    <= '0;
        end else begin
            state  <= nxt;
            busy   <= (nxt == FETCH) || (nxt == DECODE) ||
                      (nxt == EXEC)  || (nxt == WB);
            halted <= (nxt == HALT);
            if (state == FETCH) begin
                if (ack) begin
                    ir   <= imem.imem_rdata;
                    tcnt <= '0;
                end else begin
                    tcnt <= tcnt + TW'(1);
                    if (to_hit) cause <= 2'b10;
                end
            end
            if (state == DECODE && bad_op) cause <= 2'b01;
            if (state == WB) begin
                pc      <= pc + 32'd4;
                instret <= instret + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized bench for multi_cycle_ctrl: drives memory and decoder,
// predicts per-instruction behaviour from a transaction-level model.
module tb_multi_cycle_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          TO       = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        step_mode;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [4:0]  dec_alu_op;
    logic        dec_rf_we;
    logic        rf_we;
    logic        busy;
    logic        halted;
    logic [1:0]  cause;
    logic [31:0] instret;

    multi_cycle_ctrl_if bus ();

    multi_cycle_ctrl #(
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TO),
        .TW       (8)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .step_mode  (step_mode),
        .imem       (bus.master),
        .ir         (ir),
        .pc         (pc),
        .dec_alu_op (dec_alu_op),
        .dec_rf_we  (dec_rf_we),
        .rf_we      (rf_we),
        .busy       (busy),
        .halted     (halted),
        .cause      (cause),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    // stand-in decoder: opcode 7'h7F is illegal, rd != 0 writes
    assign dec_alu_op = (ir[6:0] == 7'h7F) ? 5'b11111
                                           : {2'b00, ir[14:12]};
    assign dec_rf_we  = (ir[11:7] != 5'd0);

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_ir;
    logic [31:0] exp_ret;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[6:0] == 7'h7F) w[0] = 1'b0;
        return w;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},    32'(bus.imem_req), 0);
        chk({tag, "_rfwe"},   32'(rf_we), 0);
        chk({tag, "_pc"},     pc, RESET_PC);
        chk({tag, "_ir"},     ir, NOP);
        chk({tag, "_ret"},    instret, 0);
        chk({tag, "_busy"},   32'(busy), 0);
        chk({tag, "_halted"}, 32'(halted), 0);
        chk({tag, "_cause"},  32'(cause), 0);
    endtask

    task automatic start_pulse;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort(input string tag);
        rstn = 1'b0;
        #1;
        exp_pc  = RESET_PC;
        exp_ir  = NOP;
        exp_ret = 0;
        chk_reset(tag);
        tick();
        rstn = 1'b1;
    endtask

    // Entered with the DUT in its first FETCH cycle.
    // abort: 0 none, 1 reset during FETCH, 2 reset during WB
    task automatic run_instr(input logic [31:0] w, input int dly,
                             input bit step, input int abort);
        bit illegal;
        bit we;
        illegal = (w[6:0] == 7'h7F);
        we      = (w[11:7] != 5'd0);
        for (int k = 0; k <= dly; k++) begin
            chk("fetch_req",  32'(bus.imem_req), 1);
            chk("fetch_addr", bus.imem_addr, exp_pc);
            chk("fetch_busy", 32'(busy), 1);
            chk("fetch_rfwe", 32'(rf_we), 0);
            chk("fetch_ir",   ir, exp_ir);
            if (abort == 1 && k == dly) begin
                do_abort("rst_fetch");
                return;
            end
            start     = $urandom;
            step_mode = $urandom;
            if (k == dly) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = w;
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = $urandom;
            end
            tick();
        end
        bus.imem_ack   = $urandom;
        bus.imem_rdata = $urandom;
        exp_ir = w;
        chk("dec_ir",   ir, w);
        chk("dec_req",  32'(bus.imem_req), 0);
        chk("dec_rfwe", 32'(rf_we), 0);
        chk("dec_busy", 32'(busy), 1);
        tick();
        if (illegal) begin
            start = 1'b0;
            chk("ill_halted", 32'(halted), 1);
            chk("ill_cause",  32'(cause), 1);
            chk("ill_busy",   32'(busy), 0);
            chk("ill_pc",     pc, exp_pc);
            chk("ill_ret",    instret, exp_ret);
            chk("ill_rfwe",   32'(rf_we), 0);
            return;
        end
        chk("exec_rfwe", 32'(rf_we), 0);
        chk("exec_ir",   ir, w);
        tick();
        step_mode = step;
        chk("wb_rfwe", 32'(rf_we), 32'(we));
        chk("wb_pc",   pc, exp_pc);
        chk("wb_ret",  instret, exp_ret);
        if (abort == 2) begin
            do_abort("rst_wb");
            return;
        end
        tick();
        step_mode = $urandom;
        start     = 1'b0;
        bus.imem_ack = 1'b0;
        exp_pc  = exp_pc + 32'd4;
        exp_ret = exp_ret + 1;
        chk("ret_pc",   pc, exp_pc);
        chk("ret_cnt",  instret, exp_ret);
        chk("ret_rfwe", 32'(rf_we), 0);
        if (step) begin
            chk("step_busy", 32'(busy), 0);
            chk("step_req",  32'(bus.imem_req), 0);
            repeat ($urandom_range(0, 2)) tick();
            chk("idle_pc",  pc, exp_pc);
            chk("idle_req", 32'(bus.imem_req), 0);
            start_pulse();
        end
    endtask

    initial begin
        rstn           = 1'b0;
        start          = 1'b0;
        step_mode      = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        exp_pc  = RESET_PC;
        exp_ir  = NOP;
        exp_ret = 0;
        repeat (2) tick();
        chk_reset("reset");
        rstn = 1'b1;
        repeat (3) tick();
        chk("idle_hold_busy", 32'(busy), 0);
        chk("idle_hold_req",  32'(bus.imem_req), 0);
        start_pulse();

        run_instr(32'h0050_0093, 0, 1'b0, 0);
        for (int i = 0; i < 3; i++) run_instr(rand_word(), 0, 1'b0, 0);
        run_instr(rand_word(), 3, 1'b0, 0);
        for (int i = 0; i < 40; i++)
            run_instr(rand_word(), $urandom_range(0, 3),
                      ($urandom_range(0, 3) == 0), 0);
        for (int i = 0; i < 3; i++) run_instr(rand_word(), 0, 1'b1, 0);

        run_instr(rand_word(), 1, 1'b0, 1);
        start_pulse();
        run_instr(32'h0050_0093, 0, 1'b0, 2);
        start_pulse();
        run_instr(rand_word(), 0, 1'b0, 0);
        run_instr(rand_word(), 2, 1'b0, 0);

        for (int k = 0; k < TO; k++) begin
            chk("to_req",  32'(bus.imem_req), 1);
            chk("to_addr", bus.imem_addr, exp_pc);
            bus.imem_ack = 1'b0;
            tick();
        end
        chk("to_halted", 32'(halted), 1);
        chk("to_cause",  32'(cause), 2);
        chk("to_busy",   32'(busy), 0);
        chk("to_req_off", 32'(bus.imem_req), 0);
        chk("to_ir",     ir, exp_ir);
        chk("to_pc",     pc, exp_pc);
        bus.imem_ack = 1'b1;
        start_pulse();
        tick();
        chk("to_sticky", 32'(halted), 1);
        chk("to_sticky_req", 32'(bus.imem_req), 0);
        bus.imem_ack = 1'b0;
        do_abort("rst_halt");
        start_pulse();

        run_instr(rand_word(), 0, 1'b0, 0);
        run_instr(32'hFFFF_FFFF, $urandom_range(0, 3), 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            start_pulse();
            chk("ill_sticky",  32'(halted), 1);
            chk("ill_cause2",  32'(cause), 1);
            chk("ill_req_off", 32'(bus.imem_req), 0);
            chk("ill_pc2",     pc, exp_pc);
            chk("ill_ret2",    instret, exp_ret);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
